// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle signed product instead.
module muldiv_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RF_ADDRESS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_W-1:0]     rs1,
  input  logic [DATA_W-1:0]     rs2,
  input  logic [RF_ADDRESS-1:0] rd_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic [RF_ADDRESS-1:0] rd_out
);

  localparam int unsigned CntW = $clog2(DATA_W);

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_W-1:0]     rs1_q, rs1_d;
  logic [DATA_W-1:0]     rs2_q, rs2_d;
  logic [RF_ADDRESS-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic [RF_ADDRESS-1:0] rd_out_q, rd_out_d;

  // Operand decode
  logic              is_div, sign_a, sign_b, neg_a, neg_b;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic              div_zero, div_ovf;
  logic [DATA_W-1:0] special_res;

  assign is_div = op_q[2];
  assign sign_a = is_div ? ~op_q[0] : (op_q[1:0] != 2'b11);
  assign sign_b = is_div ? ~op_q[0] : ~op_q[1];
  assign neg_a  = sign_a & rs1_q[DATA_W-1];
  assign neg_b  = sign_b & rs2_q[DATA_W-1];
  assign abs_a  = neg_a ? -rs1_q : rs1_q;
  assign abs_b  = neg_b ? -rs2_q : rs2_q;

  assign div_zero = is_div && (rs2_q == '0);
  assign div_ovf  = is_div && !op_q[0] && (rs1_q == {1'b1, {(DATA_W-1){1'b0}}}) && (rs2_q == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op_q[1] ? rs1_q : '1;
    end else begin
      special_res = op_q[1] ? '0 : rs1_q;
    end
  end

  // Iteration datapath
  logic [DATA_W:0] mul_sum;
  logic [DATA_W:0] div_shift, div_diff;

  assign mul_sum   = {1'b0, hi_q} + ({1'b0, dvs_q} & {(DATA_W+1){lo_q[0]}});
  assign div_shift = {hi_q, lo_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};

  // Sign fix-up and output select
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix, fix_res;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

  always_comb begin
    fix_res = '0;
    if (is_div) begin
      fix_res = op_q[1] ? rem_fix : quot_fix;
    end else if (op_q[1:0] == 2'b00) begin
      fix_res = prod_fix[DATA_W-1:0];
    end else begin
      fix_res = prod_fix[2*DATA_W-1:DATA_W];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extension to 2*DATA_W keeps the low 2*DATA_W bits of the (DATA_W+1)-bit signed product.
  logic signed [2*DATA_W-1:0] fast_a, fast_b, fast_prod;

  assign fast_a    = {{DATA_W{neg_a}}, rs1_q};
  assign fast_b    = {{DATA_W{neg_b}}, rs2_q};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = funct3;
          rs1_d   = rs1;
          rs2_d   = rs2;
          rd_d    = rd_in;
          state_d = StPrep;
        end
      end
      StPrep: begin
        neg_d     = neg_a ^ neg_b;
        neg_rem_d = neg_a;
        cnt_d     = CntW'(DATA_W - 1);
        hi_d      = '0;
        dvs_d     = is_div ? abs_b : abs_a;
        lo_d      = is_div ? abs_a : abs_b;
        if (div_zero || div_ovf) begin
          result_d = special_res;
          rd_out_d = rd_q;
          state_d  = StDone;
        end else begin
          state_d = StCalc;
`ifdef MULDIV_FAST_MUL_EN
          if (!is_div) begin
            hi_d    = fast_prod[2*DATA_W-1:DATA_W];
            lo_d    = fast_prod[DATA_W-1:0];
            neg_d   = 1'b0;
            state_d = StFix;
          end
`endif
        end
      end
      StCalc: begin
        cnt_d = cnt_q - 1'b1;
        if (is_div) begin
          // Remainder in hi, dividend shifts out of lo while quotient bits shift in.
          if (!div_diff[DATA_W]) begin
            hi_d = div_diff[DATA_W-1:0];
            lo_d = {lo_q[DATA_W-2:0], 1'b1};
          end else begin
            hi_d = div_shift[DATA_W-1:0];
            lo_d = {lo_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[DATA_W:1];
          lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = fix_res;
        rd_out_d = rd_q;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A flush in DONE is ignored: the result has already been delivered.
    if (flush && (state_q != StIdle) && (state_q != StDone)) begin
      state_d  = StIdle;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected results, a negedge monitor checks done.
module tb_muldiv_unit;

  localparam int DW = 32;
  localparam int RW = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 3;
`else
  localparam int MulLat = DW + 3;
`endif
  localparam int DivLat  = DW + 3;
  localparam int SpecLat = 2;

  localparam logic [2:0] OpMul = 3'b000, OpMulh = 3'b001, OpMulhsu = 3'b010, OpMulhu = 3'b011;
  localparam logic [2:0] OpDiv = 3'b100, OpDivu = 3'b101, OpRem = 3'b110, OpRemu = 3'b111;

  logic          clk = 1'b0;
  logic          reset, start, flush;
  logic [2:0]    funct3;
  logic [DW-1:0] rs1, rs2;
  logic [RW-1:0] rd_in;
  logic          busy, done;
  logic [DW-1:0] result;
  logic [RW-1:0] rd_out;

  muldiv_unit #(.DATA_W(DW), .RF_ADDRESS(RW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] res;
    logic [RW-1:0] rd;
    int            at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   t0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no done (cycle %0d)",
                 result, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", {32'd0, result}, {32'd0, mon_e.res});
        check("rd_out", {59'd0, rd_out}, {59'd0, mon_e.rd});
        check("done_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end
  end

  task automatic launch(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [RW-1:0] rd);
    @(negedge clk);
    funct3 = f;
    rs1    = a;
    rs2    = b;
    rd_in  = rd;
    start  = 1'b1;
    t0     = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_res(input logic [DW-1:0] r, input logic [RW-1:0] rd, input int lat);
    exp_t e;
    e.res = r;
    e.rd  = rd;
    e.at  = t0 + lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 after 100 cycles, expected 0");
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [RW-1:0] rd, input logic [DW-1:0] r, input int lat);
    launch(f, a, b, rd);
    expect_res(r, rd, lat);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2 ms");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = '0;
    rs1    = '0;
    rs2    = '0;
    rd_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_rd_out", {59'd0, rd_out}, 64'd0);
    reset = 1'b0;

    // MUL with latency and busy window
    launch(OpMul, 32'd7, 32'hFFFF_FFFD, 5'd3);
    expect_res(32'hFFFF_FFEB, 5'd3, MulLat);
    check("mul_busy_first", {63'd0, busy}, 64'd1);
    repeat (MulLat - 1) @(negedge clk);
    check("mul_busy_last", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("mul_busy_after", {63'd0, busy}, 64'd0);

    run(OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, MulLat);
    run(OpMulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, MulLat);
    run(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, MulLat);

    run(OpDiv,  32'hFFFF_FFF9, 32'd2, 5'd7,  32'hFFFF_FFFD, DivLat);
    run(OpRem,  32'hFFFF_FFF9, 32'd2, 5'd8,  32'hFFFF_FFFF, DivLat);
    run(OpDivu, 32'd100,       32'd7, 5'd9,  32'd14,        DivLat);
    run(OpRemu, 32'd100,       32'd7, 5'd10, 32'd2,         DivLat);

    // Flush mid-divide: no done, outputs held
    launch(OpDiv, 32'd1000, 32'd3, 5'd11);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_result_held", {32'd0, result}, 64'd2);
    check("flush_rd_held", {59'd0, rd_out}, 64'd10);
    launch(OpMul, 32'd3, 32'd4, 5'd12);
    expect_res(32'd12, 5'd12, MulLat);
    wait_idle();

    // Flush and start together in IDLE: start dropped
    @(negedge clk);
    funct3 = OpMul;
    start  = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_idle_busy", {63'd0, busy}, 64'd0);

    // Special cases
    run(OpDivu, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, SpecLat);
    run(OpRem,  32'd5,         32'd0,         5'd14, 32'd5,         SpecLat);
    run(OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, SpecLat);
    run(OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         SpecLat);

    // Start while busy is ignored
    launch(OpDivu, 32'd100, 32'd7, 5'd17);
    expect_res(32'd14, 5'd17, DivLat);
    funct3 = OpMul;
    rs1    = 32'd9;
    rs2    = 32'd9;
    rd_in  = 5'd18;
    start  = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    check("ignored_start_busy", {63'd0, busy}, 64'd0);

    // Reset mid-op
    launch(OpDiv, 32'd1000, 32'd3, 5'd19);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_done", {63'd0, done}, 64'd0);
    check("midreset_result", {32'd0, result}, 64'd0);
    check("midreset_rd_out", {59'd0, rd_out}, 64'd0);

    run(OpRemu, 32'd100, 32'd7, 5'd20, 32'd2, DivLat);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. It sits beside the ALU in the EX stage of the 5-stage pipeline.
- The ID/EX stage launches an op with `start`.
- `busy` drives the hazard unit to hold PC, IF/ID and ID/EX while the op runs.
- A one-cycle `done` pulse delivers `result` and `rd_out` into the EX/MEM register.
- Branch/jump flush aborts an op in flight.

Parameters:
- DATA_W, 32, operand/result width; must be even, ≥ 8.
- RF_ADDRESS, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  DATA_W  multiplicand / dividend
- rs2  in  DATA_W  multiplier / divisor
- rd_in  in  RF_ADDRESS  destination register tag
- flush  in  1  abort the op in progress (PcSel)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: result valid
- result  out  DATA_W  registered result; held until the next done
- rd_out  out  RF_ADDRESS  tag captured at start; held with result

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, rd_out=0; all internal registers cleared. Reset mid-op aborts the op with no done.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE, start=1: latch funct3, rs1, rs2, rd_in → PREP. start while not IDLE is ignored; the caller must hold it off via busy.
- PREP:
  - Take absolute values per signedness: MULH signs both operands, MULHSU signs rs1 only, DIV/REM sign both, U-ops sign neither.
  - Record the result-sign flags.
  - Load counter = DATA_W-1 → CALC.
  - Special cases go PREP → DONE directly:
    - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1.
    - Signed overflow (rs1 = 1 followed by DATA_W-1 zeros, i.e. most negative; rs2 = all-ones): DIV gives rs1, REM gives 0.
- CALC: one bit per cycle for DATA_W cycles; counter decrements and CALC exits when it reaches 0.
  - Multiply: shift-add into a 2·DATA_W product.
  - Divide: restoring divide.
- FIX:
  - Apply two's-complement negation where required: product sign = XOR of operand signs; quotient sign = XOR; remainder sign = dividend sign.
  - Select the output: MUL → low half; MULH/MULHSU/MULHU → high half; DIV/DIVU → quotient; REM/REMU → remainder.
  - → DONE.
- DONE: done=1, result and rd_out valid; → IDLE next cycle.
- Latency (start seen in cycle 0): normal done in cycle DATA_W+3 (35 for 32 bits); special-case done in cycle 2. Throughput: next start accepted in the cycle after done.
- flush:
  - In any non-IDLE state: → IDLE next cycle, no done; result and rd_out unchanged.
  - flush and start together in IDLE: flush wins, start dropped.
  - flush in the DONE cycle: done still asserts; the pipeline is responsible for discarding it.
- All arithmetic is modulo 2^DATA_W for outputs; intermediates are DATA_W+1 (remainder) and 2·DATA_W (product) bits wide.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - Multiply ops use a single combinational DATA_W+1 × DATA_W+1 signed product registered in PREP.
  - Path is PREP → FIX → DONE, skipping CALC; multiply done in cycle 3.
  - Divide is unchanged.
- Not defined: all ops iterate through CALC as above; no wide multiplier is inferred.

Test Plan:
1. DATA_W=32. MUL rs1=7, rs2=0xFFFFFFFD → result=0xFFFFFFEB, rd_out=rd_in, done in cycle 35 (cycle 3 with MULDIV_FAST_MUL_EN); busy high in cycles 1–35.
2. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 by 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 by 7 → 14. REMU same operands → 2.
4. DIVU 5 by 0 → 0xFFFFFFFF, done in cycle 2. REM 5 by 0 → 5. DIV 0x80000000 by 0xFFFFFFFF → 0x80000000. REM same operands → 0.
5. Start DIV, assert flush in cycle 10 → busy=0 in cycle 11, no done; result keeps its old value. A new MUL 3×4 started in cycle 12 → 12 in cycle 47.
6. Assert start while busy → ignored; the first op completes with its own result. Assert reset in cycle 20 of an op → all outputs 0 next cycle, no done.
